sifted_key_packer: RTL
======================

# sifted_key_packer

Parametrised sifted-key packer for the Alice and Bob sifting datapaths. It accepts 0..LANES sifted bits per cycle and packs them MSB-first into WORD_W-bit words. Each completed word is written to the sifted-key BRAM port A at an incrementing address. At end of frame it pads and writes any partial word, then reports the bit and word counts with a one-cycle finish pulse. It replaces the fixed 64-bit, single-bit-per-cycle writer and adds multi-lane input, tail padding, overflow detection and restart.

## Interface
- WORD_W, 64, BRAM word width; power of two, ≥ LANES
- DEPTH, 32768, BRAM depth in words
- ADDR_W, 15, address width; 2^ADDR_W ≥ DEPTH
- LANES, 4, maximum sifted bits per input beat
- PAD_BIT, 1'b0, fill value for unused tail bits of the last word
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; clears counters and enters RUN
- in_valid  in  1  beat qualifier
- in_bits  in  LANES  sifted bits; in_bits[0] is the earliest bit
- in_cnt  in  $clog2(LANES+1)  number of valid bits in in_bits[in_cnt-1:0]
- in_last  in  1  with in_valid, marks the final beat of the frame
- in_ready  out  1  high only in RUN
- siftedkey_dina  out  WORD_W  packed word; first bit is at bit WORD_W-1
- siftedkey_addra  out  ADDR_W  word address
- siftedkey_clka  out  1  = clk
- siftedkey_ena  out  1  write enable
- siftedkey_wea  out  1  write strobe; equal to siftedkey_ena
- key_bits  out  ADDR_W+$clog2(WORD_W)+1  number of bits stored in this frame
- word_count  out  ADDR_W+1  number of words written in this frame
- overflow  out  1  sticky; bits were dropped because the BRAM was full
- sifting_finish  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, RUN, PAD, DONE. On reset: state IDLE, all outputs 0, in_ready 0.
- IDLE → RUN on start. start clears the accumulator, residue count, address, key_bits, word_count and overflow.
- start while in RUN: aborts the frame. All counters and the partial word are cleared, nothing is written, the block stays in RUN. start in PAD or DONE is ignored.
- Acceptance: a beat is accepted when in_valid && in_ready. If in_cnt > LANES, the block uses LANES.
- Packing:
  - Accepted bits are appended in order in_bits[0], in_bits[1], ... after the current residue.
  - When the residue reaches WORD_W, that word is written and the remaining bits carry into the next word.
  - At most one word completes per beat, because LANES ≤ WORD_W.
- Full:
  - word_count == DEPTH means the BRAM is full.
  - While full, further bits are dropped: no write, key_bits does not advance, overflow is set.
  - Acceptance continues so the source never stalls.
- Counters: key_bits counts stored bits only. word_count counts writes. addra equals word_count at the time of the write; it never wraps.
- Transitions at frame end:
  - RUN → PAD on an accepted in_last.
  - PAD writes the residue if it is nonzero and not full. Tail bits are filled with PAD_BIT. PAD → DONE.
  - DONE drives sifting_finish for one cycle, then DONE → IDLE.
  - key_bits, word_count and overflow hold until the next start.
- in_last with in_cnt = 0 is legal.

## Timing
- All outputs are registered.
- Write latency: a beat sampled at edge t that completes a word drives ena/wea/dina/addra high from edge t to t+1, so the write lands at edge t+1.
- Last beat sampled at edge t:
  - the completed-word write (if any) is active t..t+1;
  - the padded residue write (if any) is active t+1..t+2;
  - sifting_finish is high t+2..t+3.
  - These latencies are fixed regardless of whether writes occur.
- in_ready falls at edge t (the last-beat edge) and rises one edge after a start sampled in IDLE.
- Counters update at the same edge as the write strobe they count.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The partial word is discarded and no finish pulse is issued.

## Test plan
- Alternating bits, no residue (LANES=1): start, then 128 beats alternating 1,0, with last on beat 128 → writes 0xAAAA_AAAA_AAAA_AAAA at addr 0 and 1; no PAD write; finish 2 cycles after the last edge; key_bits=128, word_count=2.
- All-ones with tail padding (LANES=4): 17 beats of in_cnt=4 all ones, then a last beat with in_cnt=3 of ones → addr0 = 0xFFFF_FFFF_FFFF_FFFF; addr1 = 0xFE00_0000_0000_0000 written in PAD; key_bits=71.
- Word-straddling beat: 62 zero bits, then a beat with in_cnt=4 and in_bits=4'b1101, then last with in_cnt=0 → addr0 = 0x0000_0000_0000_0002; addr1 = 0xC000_0000_0000_0000; key_bits=66.
- Overflow (DEPTH=4, ADDR_W=2): 300 ones with last → 4 writes at addr 0..3; overflow=1; key_bits=256, word_count=4; no PAD write.
- Restart: start again after 40 bits, then 64 zero bits with last → a single write of 0 at addr 0; key_bits=64; no stale bits in the word.
- Reset mid-frame: assert rst_n=0 after 100 bits → all outputs 0 and in_ready 0 while in reset; no sifting_finish; after reset and start, the first write goes to addr 0.

Source files
------------

// File: rtl/sifted_key_packer.sv
// Sifted-key packer: gathers 0..LANES bits per beat MSB-first into WORD_W-bit
// words, writes completed words to BRAM port A, pads the tail word at frame end
// and reports bit/word counts with a one-cycle finish pulse.
module sifted_key_packer #(
    parameter int unsigned  WORD_W  = 64,
    parameter int unsigned  DEPTH   = 32768,
    parameter int unsigned  ADDR_W  = 15,
    parameter int unsigned  LANES   = 4,
    parameter logic         PAD_BIT = 1'b0,
    localparam int unsigned CNT_W   = $clog2(LANES + 1),
    localparam int unsigned KB_W    = ADDR_W + $clog2(WORD_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [LANES-1:0]  in_bits,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic              in_last,
    output logic              in_ready,
    output logic [WORD_W-1:0] siftedkey_dina,
    output logic [ADDR_W-1:0] siftedkey_addra,
    output logic              siftedkey_clka,
    output logic              siftedkey_ena,
    output logic              siftedkey_wea,
    output logic [KB_W-1:0]   key_bits,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic              sifting_finish
);

    localparam int unsigned   RES_W    = $clog2(WORD_W) + 1;
    localparam int unsigned   EXT_W    = WORD_W + LANES;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPad, StDone} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [KB_W-1:0]   kbits_q, kbits_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic              ovf_q, ovf_d;
    logic              ena_q, ena_d;
    logic [WORD_W-1:0] dina_q, dina_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic              fin_q, fin_d;

    logic [EXT_W-1:0]  ext;
    logic [WORD_W-1:0] pad_word;
    logic              full;
    int unsigned       n, res, nsum, carry;

    // Next-state: bit packing, word writes, tail padding and frame sequencing.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        res_d    = res_q;
        kbits_d  = kbits_q;
        wcnt_d   = wcnt_q;
        ovf_d    = ovf_q;
        ena_d    = 1'b0;
        dina_d   = dina_q;
        addra_d  = addra_q;
        fin_d    = 1'b0;
        ext      = {acc_q, {LANES{1'b0}}};
        pad_word = '0;
        full     = (wcnt_q == FULL_CNT);
        res      = 32'(res_q);
        n        = (32'(in_cnt) > LANES) ? LANES : 32'(in_cnt);
        nsum     = res + n;
        carry    = (nsum >= WORD_W) ? nsum - WORD_W : 0;

        // Bit at stream position p lands at ext[EXT_W-1-p]; positions past
        // WORD_W fall into the low LANES bits and become the carry.
        for (int unsigned p = 0; p < EXT_W; p++) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (i < n && res + i == p) begin
                    ext[EXT_W-1-p] = in_bits[i];
                end
            end
        end
        for (int unsigned j = 0; j < WORD_W; j++) begin
            pad_word[WORD_W-1-j] = (j < res) ? acc_q[WORD_W-1-j] : PAD_BIT;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    res_d   = '0;
                    kbits_d = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                    addra_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (start) begin
                    acc_d   = '0;
                    res_d   = '0;
                    kbits_d = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                    addra_d = '0;
                end else if (in_valid) begin
                    if (full) begin
                        if (n != 0) ovf_d = 1'b1;
                    end else if (nsum >= WORD_W) begin
                        ena_d   = 1'b1;
                        dina_d  = ext[EXT_W-1 -: WORD_W];
                        addra_d = wcnt_q[ADDR_W-1:0];
                        wcnt_d  = wcnt_q + 1'b1;
                        if (wcnt_q == LAST_CNT) begin
                            // Final BRAM word: carried bits have nowhere to go.
                            if (carry != 0) ovf_d = 1'b1;
                            kbits_d = kbits_q + KB_W'(n - carry);
                            acc_d   = '0;
                            res_d   = '0;
                        end else begin
                            kbits_d = kbits_q + KB_W'(n);
                            acc_d   = WORD_W'(ext[LANES-1:0]) << (WORD_W - LANES);
                            res_d   = RES_W'(carry);
                        end
                    end else begin
                        kbits_d = kbits_q + KB_W'(n);
                        acc_d   = ext[EXT_W-1 -: WORD_W];
                        res_d   = RES_W'(nsum);
                    end
                    if (in_last) state_d = StPad;
                end
            end
            StPad: begin
                if (res_q != '0 && !full) begin
                    ena_d   = 1'b1;
                    dina_d  = pad_word;
                    addra_d = wcnt_q[ADDR_W-1:0];
                    wcnt_d  = wcnt_q + 1'b1;
                end
                acc_d   = '0;
                res_d   = '0;
                state_d = StDone;
            end
            StDone: begin
                fin_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset drops any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            res_q   <= '0;
            kbits_q <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            ena_q   <= 1'b0;
            dina_q  <= '0;
            addra_q <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            kbits_q <= kbits_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            ena_q   <= ena_d;
            dina_q  <= dina_d;
            addra_q <= addra_d;
            fin_q   <= fin_d;
        end
    end

    assign in_ready        = (state_q == StRun);
    assign siftedkey_clka  = clk;
    assign siftedkey_ena   = ena_q;
    assign siftedkey_wea   = ena_q;
    assign siftedkey_dina  = dina_q;
    assign siftedkey_addra = addra_q;
    assign key_bits        = kbits_q;
    assign word_count      = wcnt_q;
    assign overflow        = ovf_q;
    assign sifting_finish  = fin_q;

endmodule
